// File: rtl/multi_pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM controller.
package multi_pwm_pkg;

    localparam int unsigned PCT_W = 7;

    typedef logic [PCT_W-1:0] pct_t;

    localparam pct_t PCT_MAX = pct_t'(100);

    typedef enum logic [1:0] {
        RAMP_HOLD = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_dir_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic ramp_dir_t ramp_dir(input pct_t duty, input pct_t target);
        if (duty < target) return RAMP_UP;
        if (duty > target) return RAMP_DOWN;
        return RAMP_HOLD;
    endfunction

endpackage

// File: rtl/multi_pwm_ctrl_if.sv
// Control/status bundle of multi_pwm_ctrl: encoder, channel select/enable, PWM and display outputs.
interface multi_pwm_ctrl_if
    import multi_pwm_pkg::*;
#(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned SEL_W = 2
);
    logic             ENC_A;
    logic             ENC_B;
    logic [SEL_W-1:0] CH_SEL;
    logic [N_CH-1:0]  CH_EN;
    logic [N_CH-1:0]  PWM_OUT;
    pct_t             DUTY_PCT;
    pct_t             TARGET_PCT;
    logic             PERIOD_TICK;

    modport master (
        output ENC_A, ENC_B, CH_SEL, CH_EN,
        input  PWM_OUT, DUTY_PCT, TARGET_PCT, PERIOD_TICK
    );

    modport slave (
        input  ENC_A, ENC_B, CH_SEL, CH_EN,
        output PWM_OUT, DUTY_PCT, TARGET_PCT, PERIOD_TICK
    );
endinterface

// File: rtl/multi_pwm_ctrl_quad_enc_step.sv
// Quadrature encoder front end: 2-FF synchronisers, A-phase history, x1 decode into INC/DEC pulses.
module quad_enc_step (
    input  logic CLK,
    input  logic RST_N,
    input  logic ENC_A,
    input  logic ENC_B,
    output logic INC,
    output logic DEC
);
    logic a_meta_q, a_sync_q, a_hist_q;
    logic b_meta_q, b_sync_q;
    logic a_rise;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            a_hist_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
        end else begin
            a_meta_q <= ENC_A;
            a_sync_q <= a_meta_q;
            a_hist_q <= a_sync_q;
            b_meta_q <= ENC_B;
            b_sync_q <= b_meta_q;
        end
    end

    // B is sampled alongside A, so its level at the A rising edge sets the direction.
    assign a_rise = a_sync_q & ~a_hist_q;
    assign INC    = a_rise & ~b_sync_q;
    assign DEC    = a_rise &  b_sync_q;
endmodule

// File: rtl/multi_pwm_ctrl.sv
// N-channel PWM generator; encoder trims the selected channel's target, active duties ramp toward targets.
module multi_pwm_ctrl
    import multi_pwm_pkg::*;
#(
    parameter int unsigned N_CH         = 3,
    parameter int unsigned STEP         = 500,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RAMP_PERIODS = 10,
    parameter int unsigned SEL_W        = sel_width(N_CH)
) (
    input  logic            CLK,
    input  logic            RST_N,
    multi_pwm_ctrl_if.slave bus
);
    localparam int unsigned       PERIOD    = 100 * STEP;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  STEP_C    = CNT_W'(STEP);
    localparam int unsigned       RAMP_W    = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
    localparam logic [SEL_W:0]    N_CH_C    = (SEL_W + 1)'(N_CH);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    pct_t              duty_pct_q, tgt_pct_q;
    logic              tick, ramp_step;
    logic              enc_inc, enc_dec;

    pct_t              duty_w [N_CH];
    pct_t              tgt_w  [N_CH];
    logic [N_CH-1:0]   pwm_w;

    quad_enc_step u_enc (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ENC_A (bus.ENC_A),
        .ENC_B (bus.ENC_B),
        .INC   (enc_inc),
        .DEC   (enc_dec)
    );

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign sel_d = ({1'b0, bus.CH_SEL} < N_CH_C) ? bus.CH_SEL : sel_q;

    always_comb begin
        ramp_d    = ramp_q;
        ramp_step = 1'b0;
        if (tick) begin
            if (ramp_q == RAMP_LAST) begin
                ramp_d    = '0;
                ramp_step = 1'b1;
            end else begin
                ramp_d = ramp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q      <= '0;
            ramp_q     <= '0;
            sel_q      <= '0;
            duty_pct_q <= '0;
            tgt_pct_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ramp_q     <= ramp_d;
            sel_q      <= sel_d;
            duty_pct_q <= duty_w[sel_q];
            tgt_pct_q  <= tgt_w[sel_q];
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pct_t             tgt_q, tgt_d;
        pct_t             duty_q, duty_d;
        logic [CNT_W-1:0] shadow_q, shadow_d;
        logic             pwm_q, pwm_d;
        logic             hit;
        ramp_dir_t        dir;

        assign hit = (sel_q == SEL_W'(g));
        assign dir = ramp_dir(duty_q, tgt_q);

        // Ramp compares against the pre-update target; a coincident encoder step shows up next ramp step.
        always_comb begin
            tgt_d = tgt_q;
            if (hit && enc_inc && (tgt_q < PCT_MAX)) tgt_d = tgt_q + 1'b1;
            if (hit && enc_dec && (tgt_q != '0))     tgt_d = tgt_q - 1'b1;

            duty_d = duty_q;
            if (ramp_step) begin
                unique case (dir)
                    RAMP_UP:   duty_d = duty_q + 1'b1;
                    RAMP_DOWN: duty_d = duty_q - 1'b1;
                    default:   duty_d = duty_q;
                endcase
            end

            // Shadow takes the post-ramp duty so the next period starts with the new value.
            shadow_d = shadow_q;
            if (tick) shadow_d = CNT_W'(duty_d) * STEP_C;

            pwm_d = bus.CH_EN[g] & (cnt_q < shadow_q);
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                tgt_q    <= '0;
                duty_q   <= '0;
                shadow_q <= '0;
                pwm_q    <= 1'b0;
            end else begin
                tgt_q    <= tgt_d;
                duty_q   <= duty_d;
                shadow_q <= shadow_d;
                pwm_q    <= pwm_d;
            end
        end

        assign duty_w[g] = duty_q;
        assign tgt_w[g]  = tgt_q;
        assign pwm_w[g]  = pwm_q;
    end

    assign bus.PWM_OUT     = pwm_w;
    assign bus.DUTY_PCT    = duty_pct_q;
    assign bus.TARGET_PCT  = tgt_pct_q;
    assign bus.PERIOD_TICK = tick;
endmodule

// File: tb/tb_multi_pwm_ctrl.sv
// Bench for multi_pwm_ctrl: instance A (STEP=4, RAMP_PERIODS=2), instance B (STEP=1, RAMP_PERIODS=1).
module tb_multi_pwm_ctrl;
    import multi_pwm_pkg::*;

    localparam int unsigned NCH = 3;

    typedef virtual multi_pwm_ctrl_if #(.N_CH(NCH), .SEL_W(2)) vif_t;

    typedef struct {
        string name;
        int    exp;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        bit         down;
        int         n;
        logic [2:0] en;
        int         exp_tgt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_na, rst_nb;
    always #5 clk = ~clk;

    multi_pwm_ctrl_if #(.N_CH(NCH), .SEL_W(2)) ia ();
    multi_pwm_ctrl_if #(.N_CH(NCH), .SEL_W(2)) ib ();

    multi_pwm_ctrl #(.N_CH(NCH), .STEP(4), .CNT_W(16), .RAMP_PERIODS(2), .SEL_W(2)) dut_a (
        .CLK(clk), .RST_N(rst_na), .bus(ia)
    );
    multi_pwm_ctrl #(.N_CH(NCH), .STEP(1), .CNT_W(8), .RAMP_PERIODS(1), .SEL_W(2)) dut_b (
        .CLK(clk), .RST_N(rst_nb), .bus(ib)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    vif_t va, vb;
    vec_t vecs[7];

    task automatic expect_val(input string name, input int exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic check_val(input int act);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got %0d, nothing expected", act);
        end else begin
            e = sb.pop_front();
            if (act == e.exp) n_pass++;
            else $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
        end
    endtask

    task automatic enc(input vif_t v, input bit down, input int n);
        for (int i = 0; i < n; i++) begin
            v.ENC_B = down;
            repeat (2) @(negedge clk);
            v.ENC_A = 1'b1;
            repeat (4) @(negedge clk);
            v.ENC_A = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_duty(input vif_t v, input string name, input int exp, input int limit);
        int cyc = 0;
        expect_val(name, exp);
        while ((int'(v.DUTY_PCT) != exp) && (cyc < limit)) begin
            @(negedge clk);
            cyc++;
        end
        check_val(int'(v.DUTY_PCT));
    endtask

    // Counts high samples of one channel over two consecutive periods; optional A pulse at sample poke_at.
    task automatic measure(input vif_t v, input int ch, input int per, input int poke_at,
                           output int h0, output int h1);
        int guard = 0;
        h0 = 0;
        h1 = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!v.PERIOD_TICK && (guard < 4 * per));
        @(negedge clk);
        for (int i = 0; i < 2 * per; i++) begin
            if (i == poke_at)     v.ENC_A = 1'b1;
            if (i == poke_at + 4) v.ENC_A = 1'b0;
            @(negedge clk);
            if (v.PWM_OUT[ch]) begin
                if (i < per) h0++;
                else         h1++;
            end
        end
    endtask

    initial begin
        int h0, h1, cyc, guard;
        logic any_hi;

        va = ia;
        vb = ib;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        ia.ENC_A = 1'b0; ia.ENC_B = 1'b0; ia.CH_SEL = 2'd0; ia.CH_EN = 3'b111;
        ib.ENC_A = 1'b0; ib.ENC_B = 1'b0; ib.CH_SEL = 2'd0; ib.CH_EN = 3'b111;

        vecs[0] = '{2'd1, 1'b0, 30, 3'b111, 30};
        vecs[1] = '{2'd0, 1'b0,  0, 3'b110,  0};
        vecs[2] = '{2'd2, 1'b1,  0, 3'b110,  0};
        vecs[3] = '{2'd3, 1'b0,  2, 3'b110,  2};
        vecs[4] = '{2'd3, 1'b1,  5, 3'b110,  0};
        vecs[5] = '{2'd0, 1'b0,  5, 3'b110,  5};
        vecs[6] = '{2'd1, 1'b0,  0, 3'b110, 30};

        // ---- instance A: reset state and period length ----
        repeat (5) @(negedge clk);
        expect_val("a_rst_pwm", 0);    check_val(int'(ia.PWM_OUT));
        expect_val("a_rst_duty", 0);   check_val(int'(ia.DUTY_PCT));
        expect_val("a_rst_target", 0); check_val(int'(ia.TARGET_PCT));
        expect_val("a_rst_tick", 0);   check_val(int'(ia.PERIOD_TICK));
        rst_na = 1'b1;

        guard = 0;
        do begin @(negedge clk); guard++; end while (!ia.PERIOD_TICK && guard < 1000);
        cyc = 0;
        any_hi = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            any_hi = any_hi | (|ia.PWM_OUT);
        end while (!ia.PERIOD_TICK && cyc < 1000);
        expect_val("a_tick_interval", 400); check_val(cyc);
        expect_val("a_idle_pwm", 0);        check_val(int'(any_hi));

        // ---- instance A: table of encoder / select vectors ----
        for (int k = 0; k < 7; k++) begin
            ia.CH_EN  = vecs[k].en;
            ia.CH_SEL = vecs[k].sel;
            repeat (3) @(negedge clk);
            expect_val($sformatf("a_vec%0d_target", k), vecs[k].exp_tgt);
            enc(va, vecs[k].down, vecs[k].n);
            check_val(int'(ia.TARGET_PCT));
        end

        wait_duty(va, "a_ch1_duty30", 30, 30000);
        measure(va, 1, 400, -1, h0, h1);
        expect_val("a_ch1_high_p0", 120); check_val(h0);
        expect_val("a_ch1_high_p1", 120); check_val(h1);
        measure(va, 2, 400, -1, h0, h1);
        expect_val("a_ch2_high", 0); check_val(h0 + h1);

        ia.CH_SEL = 2'd0;
        wait_duty(va, "a_ch0_duty_disabled", 5, 6000);
        expect_val("a_ch0_target", 5); check_val(int'(ia.TARGET_PCT));
        measure(va, 0, 400, -1, h0, h1);
        expect_val("a_ch0_high_disabled", 0); check_val(h0 + h1);
        ia.CH_SEL = 2'd2;
        repeat (3) @(negedge clk);
        expect_val("a_ch2_duty", 0); check_val(int'(ia.DUTY_PCT));

        // ---- instance B: glitch-free update, saturation, async reset ----
        rst_nb = 1'b1;
        repeat (3) @(negedge clk);
        expect_val("b_target20", 20);
        enc(vb, 1'b0, 20);
        check_val(int'(ib.TARGET_PCT));
        wait_duty(vb, "b_duty20", 20, 4000);

        ib.ENC_B = 1'b0;
        measure(vb, 0, 100, 40, h0, h1);
        expect_val("b_glitch_cur_period", 20);  check_val(h0);
        expect_val("b_glitch_next_period", 21); check_val(h1);
        expect_val("b_target21", 21);           check_val(int'(ib.TARGET_PCT));

        expect_val("b_target98", 98);
        enc(vb, 1'b0, 77);
        check_val(int'(ib.TARGET_PCT));
        expect_val("b_target_sat100", 100);
        enc(vb, 1'b0, 5);
        check_val(int'(ib.TARGET_PCT));
        wait_duty(vb, "b_duty100", 100, 12000);
        measure(vb, 0, 100, -1, h0, h1);
        expect_val("b_full_high", 200); check_val(h0 + h1);

        expect_val("b_target_sat0", 0);
        enc(vb, 1'b1, 120);
        check_val(int'(ib.TARGET_PCT));
        wait_duty(vb, "b_duty57", 57, 6000);

        guard = 0;
        while (!ib.PWM_OUT[0] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        expect_val("b_pwm_high_before_rst", 1); check_val(int'(ib.PWM_OUT[0]));
        rst_nb = 1'b0;
        #1;
        expect_val("b_rst_pwm", 0);    check_val(int'(ib.PWM_OUT));
        expect_val("b_rst_duty", 0);   check_val(int'(ib.DUTY_PCT));
        expect_val("b_rst_target", 0); check_val(int'(ib.TARGET_PCT));
        expect_val("b_rst_tick", 0);   check_val(int'(ib.PERIOD_TICK));
        repeat (3) @(negedge clk);
        rst_nb = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ib.CH_SEL = 2'(c);
            repeat (3) @(negedge clk);
            expect_val($sformatf("b_post_rst_target_ch%0d", c), 0); check_val(int'(ib.TARGET_PCT));
            expect_val($sformatf("b_post_rst_duty_ch%0d", c), 0);   check_val(int'(ib.DUTY_PCT));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multi_pwm_ctrl.md
Name: multi_pwm_ctrl

Overview:
- Parametrised N-channel PWM generator with encoder-driven duty control.
- A quadrature encoder adjusts the target duty (in percent) of the currently selected channel. Every channel ramps its active duty toward its target one percent at a time, and new duty values take effect only at PWM period boundaries, so no output glitches.
- Successor to the single-frequency, one-hot motor/LED PWM top. It drives the motor-reducer, DC motor and LED simultaneously, each at an independent duty.
- Also exports the selected channel's percentage for the display block.

Parameters:
- N_CH, 3, number of PWM channels (1..8).
- STEP, 500, clock cycles per 1 % of duty. PERIOD = 100*STEP (default 50000 = 1 kHz at 50 MHz).
- CNT_W, 16, period counter width. Must satisfy 2**CNT_W > 100*STEP.
- RAMP_PERIODS, 10, PWM periods between 1 % ramp steps of the active duty.
- SEL_W, 2, width of the channel index, equal to max(1, clog2(N_CH)).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset. Deassertion is synchronised externally.
- ENC_A  in  1  encoder phase A, asynchronous.
- ENC_B  in  1  encoder phase B, asynchronous.
- CH_SEL  in  SEL_W  channel adjusted by the encoder. Values >= N_CH are ignored; the last valid selection is held.
- CH_EN  in  N_CH  per-channel output enable.
- PWM_OUT  out  N_CH  PWM outputs.
- DUTY_PCT  out  7  active duty of the selected channel, 0..100.
- TARGET_PCT  out  7  target duty of the selected channel, 0..100.
- PERIOD_TICK  out  1  one-cycle pulse on the last cycle of each PWM period.

Behaviour:
- Reset (async, RST_N=0):
  - Period counter = 0; all targets = 0; all active duties = 0; all shadow duties = 0.
  - PWM_OUT = 0, DUTY_PCT = 0, TARGET_PCT = 0, PERIOD_TICK = 0.
  - Encoder synchronisers = 0; selected-channel register = 0; ramp counter = 0.
  - Reset mid-period forces all outputs low immediately.
- Input synchronisation: ENC_A and ENC_B each pass through a 2-FF synchroniser plus one history FF.
- Encoder decode (x1 per detent):
  - A rising edge (synced A = 1, history = 0) with synced B = 0 gives +1 (increment).
  - A rising edge with synced B = 1 gives -1 (decrement).
  - Edge to target update latency: 3 cycles from the ENC_A transition at the synchroniser input.
- Target update:
  - Only the selected channel's target changes.
  - Saturates at 0 and 100; no wrap-around.
  - The selected-channel register loads CH_SEL when CH_SEL < N_CH.
- Period counter:
  - Counts 0..100*STEP-1, then wraps to 0.
  - PERIOD_TICK = 1 when the counter = 100*STEP-1.
- Ramp, shadow load and cycle-level timing:
  - On each PERIOD_TICK the ramp counter increments. At RAMP_PERIODS-1 it clears and becomes a ramp step.
  - On a ramp step, each active duty moves one percent toward its target (+1 if below, -1 if above, hold if equal).
  - On every PERIOD_TICK, each shadow duty loads its compare value, duty*STEP (registered multiply-by-constant), so the new value applies from counter = 0 of the next period.
  - A target change during a period never alters the current period.
- Output:
  - PWM_OUT[i] = CH_EN[i] AND (counter < shadow_cmp[i]). Registered, so one cycle behind the counter.
  - Duty 0 gives a constant low output; duty 100 gives a constant high output (cmp = PERIOD > every count).
  - CH_EN = 0 forces the output low, but ramping continues.
- Simultaneous events:
  - An encoder step coinciding with a ramp step: the target update and the ramp both use the pre-update target; the new target is seen at the next ramp step.
  - A CH_SEL change coinciding with an encoder edge: the edge applies to the previously registered channel.
- DUTY_PCT and TARGET_PCT are registered muxes of the selected channel's active duty and target.

Decomposition:
- Package multi_pwm_pkg:
  - PCT_MAX = 100; pct_t = 7-bit unsigned.
  - Function for the clog2-based SEL_W.
  - Ramp direction encoding (UP, DOWN, HOLD).
- Natural sub-module: quad_enc_step. It contains the synchroniser, history FF and decode, and outputs the single-cycle pulses INC and DEC.
- Per-channel ramp, shadow and compare logic is a generate loop inside multi_pwm_ctrl.

Test Plan:
- Reset: hold RST_N=0 for 5 cycles, then release with STEP=4 → all PWM_OUT=0, DUTY_PCT=0, PERIOD_TICK pulses every 400 cycles.
- Encoder up, CH_SEL=1: 30 A-rising edges with B=0 → TARGET_PCT=30. After 30*RAMP_PERIODS periods, DUTY_PCT=30 and PWM_OUT[1] is high for 120 of 400 cycles. Channels 0 and 2 stay at 0.
- Saturation: from target 98, 5 increments → TARGET_PCT=100, and PWM_OUT is constant high once active duty reaches 100. Then 120 decrements → target 0, no wrap.
- Glitch-free update: raise the target mid-period with RAMP_PERIODS=1 → current period high time unchanged; the next period reflects +1 %.
- Channel select: CH_SEL=3 with N_CH=3 → selection held at the previous channel, encoder edges still adjust it. CH_EN[0]=0 → PWM_OUT[0]=0 while DUTY_PCT of channel 0 keeps ramping.
- Async reset mid-ramp: assert RST_N at active duty 57 % → PWM_OUT drops within the same cycle; after release, targets and duties = 0.
